// File: rtl/hba_gpiox_pkg.sv
// Shared definitions for the HBA GPIO controller: register function codes,
// address field widths, debounce counter width and bus FSM encoding.
package hba_gpiox_pkg;

  localparam int FUNC_W = 3;
  localparam int BANK_W = 3;
  localparam int DEB_W  = 8;

  typedef enum logic [FUNC_W-1:0] {
    FN_DIR     = 3'd0,
    FN_PINS    = 3'd1,
    FN_INTR_EN = 3'd2,
    FN_RISE_EN = 3'd3,
    FN_FALL_EN = 3'd4,
    FN_STATUS  = 3'd5,
    FN_DEB     = 3'd6,
    FN_RSVD    = 3'd7
  } func_t;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'd0,
    BUS_ACK  = 2'd1,
    BUS_WAIT = 2'd2
  } bus_state_t;

endpackage

// File: rtl/hba_gpiox_pin.sv
// One GPIO input lane: 2-flop synchroniser, tick-based debounce filter and
// edge detection qualified by direction and per-edge enables.
module hba_gpiox_pin
  import hba_gpiox_pkg::*;
(
  input  logic             hba_clk,
  input  logic             hba_reset,
  input  logic             tick,
  input  logic             pad,
  input  logic [DEB_W-1:0] deb_ticks,
  input  logic             dir,
  input  logic             rise_en,
  input  logic             fall_en,
  output logic             filt,
  output logic             rise,
  output logic             fall
);

  logic             s1;
  logic             s2;
  logic             filt_prev;
  logic [DEB_W-1:0] cnt;
  logic [DEB_W:0]   cnt_inc;

  // One extra bit so a counter left above a lowered threshold still compares true.
  assign cnt_inc = {1'b0, cnt} + (DEB_W + 1)'(1);

  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      filt      <= 1'b0;
      filt_prev <= 1'b0;
      cnt       <= '0;
    end else begin
      s1        <= pad;
      s2        <= s1;
      filt_prev <= filt;
      if (deb_ticks == '0) begin
        filt <= s2;
        cnt  <= '0;
      end else if (s2 == filt) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt_inc >= {1'b0, deb_ticks}) begin
          filt <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt_inc[DEB_W-1:0];
        end
      end
    end
  end

  assign rise = filt & ~filt_prev & rise_en & ~dir;
  assign fall = ~filt & filt_prev & fall_en & ~dir;

endmodule

// File: rtl/hba_gpiox.sv
// HBA bus GPIO controller: banked register file behind a single-ack bus FSM,
// per-pin filtered inputs and a sticky write-1-to-clear interrupt status.
module hba_gpiox
  import hba_gpiox_pkg::*;
#(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int PERIPH_ADDR       = 0,
  parameter int NUM_PINS          = 16,
  parameter int PRESCALE_LOG2     = 10
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic                  hba_rnw,
  input  logic                  hba_select,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic [DBUS_WIDTH-1:0] hba_dbus_out,
  output logic                  hba_xferack_out,
  output logic                  interrupt_out,
  output logic [NUM_PINS-1:0]   gpio_out_en,
  output logic [NUM_PINS-1:0]   gpio_out_sig,
  input  logic [NUM_PINS-1:0]   gpio_in_sig
);

  localparam int NUM_BANKS = (NUM_PINS + DBUS_WIDTH - 1) / DBUS_WIDTH;

  bus_state_t            bus_state, bus_state_d;
  func_t                 func;
  logic [BANK_W-1:0]     bank;
  logic                  match, bank_ok, wr_en;
  logic                  unused_abus;
  logic [PRESCALE_LOG2-1:0] presc;
  logic                  tick;
  logic [NUM_PINS-1:0]   dir_q, out_q, ien_q, rise_q, fall_q, status_q;
  logic [NUM_PINS-1:0]   filt_v, rise_v, fall_v, clr_mask, pins_view;
  logic [DEB_W-1:0]      deb_q, deb_wr;
  logic [DBUS_WIDTH-1:0] deb_rd, rdata;

  function automatic logic [DBUS_WIDTH-1:0] bank_slice(input logic [NUM_PINS-1:0] v,
                                                       input logic [BANK_W-1:0]  b);
    logic [DBUS_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_PINS; i++)
      if (b == BANK_W'(i / DBUS_WIDTH)) r[i % DBUS_WIDTH] = v[i];
    return r;
  endfunction

  function automatic logic [NUM_PINS-1:0] bank_merge(input logic [NUM_PINS-1:0]   v,
                                                     input logic [BANK_W-1:0]     b,
                                                     input logic [DBUS_WIDTH-1:0] d);
    logic [NUM_PINS-1:0] r;
    r = v;
    for (int i = 0; i < NUM_PINS; i++)
      if (b == BANK_W'(i / DBUS_WIDTH)) r[i] = d[i % DBUS_WIDTH];
    return r;
  endfunction

  assign match       = hba_select &&
                       (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_ADDR_WIDTH'(PERIPH_ADDR));
  assign func        = func_t'(hba_abus[5:3]);
  assign bank        = hba_abus[2:0];
  assign bank_ok     = int'(bank) < NUM_BANKS;
  assign unused_abus = ^hba_abus[REG_ADDR_WIDTH-1:6];
  assign wr_en       = (bus_state == BUS_IDLE) && match && !hba_rnw && bank_ok;
  assign clr_mask    = (wr_en && func == FN_STATUS) ?
                       bank_merge({NUM_PINS{1'b0}}, bank, hba_dbus) : {NUM_PINS{1'b0}};
  assign pins_view   = (dir_q & out_q) | (~dir_q & filt_v);

  always_comb begin
    deb_wr = deb_q;
    deb_rd = '0;
    for (int k = 0; k < DBUS_WIDTH && k < DEB_W; k++) begin
      deb_wr[k] = hba_dbus[k];
      deb_rd[k] = deb_q[k];
    end
  end

  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) presc <= '0;
    else            presc <= presc + PRESCALE_LOG2'(1);
  end
  assign tick = &presc;

  // HBA handshake: a transfer is requested while hba_select is high with a matching
  // address; the slave answers with hba_xferack_out for exactly one cycle (read data
  // valid in that cycle, write committed on the edge entering it) and then ignores
  // the bus until hba_select drops, so one select period yields one transfer.
  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) bus_state <= BUS_IDLE;
    else            bus_state <= bus_state_d;
  end

  always_comb begin
    bus_state_d     = bus_state;
    hba_xferack_out = 1'b0;
    hba_dbus_out    = '0;
    case (bus_state)
      BUS_IDLE: if (match) bus_state_d = BUS_ACK;
      BUS_ACK: begin
        hba_xferack_out = 1'b1;
        if (hba_rnw) hba_dbus_out = rdata;
        bus_state_d = BUS_WAIT;
      end
      BUS_WAIT: if (!hba_select) bus_state_d = BUS_IDLE;
      default:  bus_state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (bank_ok) begin
      case (func)
        FN_DIR:     rdata = bank_slice(dir_q, bank);
        FN_PINS:    rdata = bank_slice(pins_view, bank);
        FN_INTR_EN: rdata = bank_slice(ien_q, bank);
        FN_RISE_EN: rdata = bank_slice(rise_q, bank);
        FN_FALL_EN: rdata = bank_slice(fall_q, bank);
        FN_STATUS:  rdata = bank_slice(status_q, bank);
        FN_DEB:     if (bank == '0) rdata = deb_rd;
        default:    rdata = '0;
      endcase
    end
  end

  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      dir_q        <= '0;
      out_q        <= '0;
      ien_q        <= '0;
      rise_q       <= '0;
      fall_q       <= '0;
      status_q     <= '0;
      deb_q        <= '0;
      gpio_out_en  <= '0;
      gpio_out_sig <= '0;
    end else begin
      if (wr_en) begin
        case (func)
          FN_DIR:     dir_q  <= bank_merge(dir_q, bank, hba_dbus);
          FN_PINS:    out_q  <= bank_merge(out_q, bank, hba_dbus);
          FN_INTR_EN: ien_q  <= bank_merge(ien_q, bank, hba_dbus);
          FN_RISE_EN: rise_q <= bank_merge(rise_q, bank, hba_dbus);
          FN_FALL_EN: fall_q <= bank_merge(fall_q, bank, hba_dbus);
          FN_DEB:     if (bank == '0) deb_q <= deb_wr;
          default:    ;
        endcase
      end
      // New events are OR-ed in after the clear so a same-cycle set wins.
      status_q     <= (status_q & ~clr_mask) | rise_v | fall_v;
      gpio_out_en  <= dir_q;
      gpio_out_sig <= out_q;
    end
  end

  assign interrupt_out = |(status_q & ien_q);

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    hba_gpiox_pin u_pin (
      .hba_clk   (hba_clk),
      .hba_reset (hba_reset),
      .tick      (tick),
      .pad       (gpio_in_sig[g]),
      .deb_ticks (deb_q),
      .dir       (dir_q[g]),
      .rise_en   (rise_q[g]),
      .fall_en   (fall_q[g]),
      .filt      (filt_v[g]),
      .rise      (rise_v[g]),
      .fall      (fall_v[g])
    );
  end

endmodule

// File: doc/hba_gpiox.md
Name: hba_gpiox

Overview:
- Parametrised HBA bus slave GPIO controller for NUM_PINS pins, organised in DBUS_WIDTH-wide banks.
- Adds over the first-generation GPIO: a 2-flop input synchroniser, a programmable debounce filter, per-pin rising/falling edge select, and a sticky write-1-to-clear interrupt status register.
- Drives tristate enables and output values to the top-level pads.
- Sits on the HBA bus alongside the other peripherals at address PERIPH_ADDR.

Parameters:
- DBUS_WIDTH, 8: HBA data bus width, which is also the bank width.
- PERIPH_ADDR_WIDTH, 4: width of the peripheral-select address field.
- REG_ADDR_WIDTH, 8: width of the register address field.
- ADDR_WIDTH, PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH: total address width.
- PERIPH_ADDR, 0: this peripheral's select value.
- NUM_PINS, 16: pin count, range 1..8*DBUS_WIDTH.
- PRESCALE_LOG2, 10: debounce tick period is 2^PRESCALE_LOG2 clocks.
- NUM_BANKS, ceil(NUM_PINS/DBUS_WIDTH): derived; not to be overridden.

Ports:
- hba_clk  in  1  sole clock.
- hba_reset  in  1  asynchronous, active-low reset.
- hba_rnw  in  1  1=read, 0=write.
- hba_select  in  1  transfer in progress.
- hba_abus  in  ADDR_WIDTH  address bus.
- hba_dbus  in  DBUS_WIDTH  write data.
- hba_dbus_out  out  DBUS_WIDTH  read data; 0 when not acking.
- hba_xferack_out  out  1  transfer acknowledge; 0 when inactive.
- interrupt_out  out  1  level interrupt.
- gpio_out_en  out  NUM_PINS  1=drive pin.
- gpio_out_sig  out  NUM_PINS  output value.
- gpio_in_sig  in  NUM_PINS  asynchronous pad inputs.

Behaviour:
- Reset: hba_reset=0 asynchronously clears every register, all outputs, all counters and all sync flops to 0. Deassertion is used as-is; no internal reset synchroniser.
- Address decode: match = hba_select && hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH]==PERIPH_ADDR. Register offset = {func[2:0], bank[2:0]} taken from hba_abus[5:0].
- Register map (per bank b; bits beyond NUM_PINS read 0 and ignore writes):
  - func0 DIR: read/write.
  - func1 PINS: a write sets the output latch. A read returns the output latch where DIR=1 and the filtered input where DIR=0.
  - func2 INTR_EN: read/write.
  - func3 RISE_EN: read/write.
  - func4 FALL_EN: read/write.
  - func5 STATUS: read; a write of 1 clears the bit.
  - func6 bank0 DEB_TICKS: read/write, low 8 bits.
  - All other offsets, and banks >= NUM_BANKS: read 0, writes ignored, still acked.
- Bus FSM:
  - IDLE -> ACK on match.
  - ACK: hba_xferack_out=1 for exactly one cycle, with read data on hba_dbus_out in that same cycle. A write commits on the clock edge that enters ACK.
  - ACK -> WAIT.
  - WAIT -> IDLE when hba_select=0.
  - No second ack while select stays high.
  - hba_dbus_out=0 outside ACK.
- Pad outputs: gpio_out_en and gpio_out_sig are registered copies of DIR and the output latch, so a pad changes 1 cycle after the write commits.
- Input path, per pin: s1 -> s2 (synchroniser) -> filt -> filt_prev.
  - DEB_TICKS=0: filt<=s2 every cycle.
  - DEB_TICKS=N>0: an 8-bit per-pin counter increments on each prescaler tick while s2!=filt, and resets to 0 whenever s2==filt. When the counter reaches N, filt<=s2 and the counter clears.
  - The prescaler is a free-running PRESCALE_LOG2-bit counter; a tick fires at wrap.
- Edge events, registered:
  - rise = filt & ~filt_prev & RISE_EN & ~DIR.
  - fall = ~filt & filt_prev & FALL_EN & ~DIR.
  - STATUS[i] <= 1 on (rise|fall).
  - A W1C clear and a set in the same cycle: the set wins.
  - STATUS sets regardless of INTR_EN.
- Latency with DEB_TICKS=0: a pad change sampled at edge E0 reaches s2 at E1, filt at E2, filt_prev at E3, and sets STATUS at E3.
- interrupt_out = |(STATUS & INTR_EN), combinational from registers. It stays high until cleared or masked.
- DIR change mid-debounce: the counter keeps running, but events for output pins are suppressed.
- A DEB_TICKS write mid-count takes effect at the next comparison. If the counter is already above the new N, filt updates on the next tick.

Decomposition:
- Package hba_gpiox_pkg:
  - func codes FN_DIR..FN_DEB.
  - offset field widths.
  - DEB_W=8.
  - bus FSM state encoding (IDLE, ACK, WAIT).
- Sub-module hba_gpiox_pin: one per pin, generated. Contains the sync flops, debounce counter, filt, filt_prev and rise/fall pulse outputs. Inputs are tick, DEB_TICKS and the enables.

Test Plan:
- Reset and outputs: reset low with bus idle -> all outputs 0.
  - Then write DIR bank0=0x0F and PINS bank0=0x05 -> gpio_out_en[7:0]=0x0F and gpio_out_sig[7:0]=0x05 one cycle after ack.
  - Read PINS -> 0x05 in the low nibble.
- Rising edge and W1C: DEB_TICKS=0, RISE_EN bank0=0x10, INTR_EN=0x10, gpio_in_sig[4] 0->1.
  - STATUS=0x10 and interrupt_out=1 at edge E3.
  - Write STATUS=0x10 -> interrupt_out=0.
  - A falling edge on pin 4 sets nothing.
- Debounce: DEB_TICKS=3, PRESCALE_LOG2=2.
  - Glitch pin 9 high for 8 clocks -> no STATUS change.
  - Hold high for 16+ clocks -> STATUS bank1 bit1 set.
- Simultaneous set and clear: fall event on pin 2 in the same cycle as a W1C of bit 2 -> STATUS bit 2 remains 1.
- Bus protocol: hold hba_select high for 10 cycles -> exactly one xferack pulse.
  - Read func7 -> 0 and acked.
  - Access with a wrong PERIPH_ADDR -> no ack, dbus_out=0.
- Reset mid-operation: assert hba_reset low during ACK -> xferack, STATUS and counters all 0 immediately, with no clock required.
